fifo_wr_arbiter: RTL

Round-robin write arbiter that shares the write port of one `fifo_un_fichero` instance between `N_REQ` producers. It grants one producer at a time for bounded bursts and stalls on FIFO full. It also sequences a one-cycle FIFO clear on request. It sits directly in front of the FIFO's `WRITE`/`DATA_IN`/`CLEAR_N` inputs and consumes its `F_FULL_N` flag.

---
 rtl/fifo_wr_arbiter_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the fifo_wr_arbiter slice: FSM encoding and
// the per-producer word counter width.
package fifo_arb_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GRANT    = 2'd1;
  localparam logic [1:0] ST_FLUSHING = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    GRANT    = ST_GRANT,
    FLUSHING = ST_FLUSHING
  } arb_state_t;

  localparam int WORD_CNT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer and FIFO write-port bundle seen by fifo_wr_arbiter (master side).
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int SIZE  = 8
);
  // Handshake: producer i raises REQ[i] with DATA_REQ[i] and holds both stable
  // until ACK[i]; a word moves exactly in a cycle where REQ[i] && ACK[i].
  // ACK is combinational and coincides with FIFO_WRITE, which is only issued
  // while F_FULL_N is high.
  logic [N_REQ-1:0]      REQ;
  logic [N_REQ*SIZE-1:0] DATA_REQ;
  logic [N_REQ-1:0]      ACK;
  logic                  F_FULL_N;
  logic                  FIFO_WRITE;
  logic [SIZE-1:0]       FIFO_DATA;
  logic                  FIFO_CLEAR_N;

  modport master (
    input  REQ, DATA_REQ, F_FULL_N,
    output ACK, FIFO_WRITE, FIFO_DATA, FIFO_CLEAR_N
  );

  modport slave (
    output REQ, DATA_REQ, F_FULL_N,
    input  ACK, FIFO_WRITE, FIFO_DATA, FIFO_CLEAR_N
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set REQ bit scanning upward from
// last_id+1 and wrapping modulo N_REQ.
module fifo_arb_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         REQ,
  input  logic [$clog2(N_REQ)-1:0] last_id,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] winner_id
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] idx;

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    valid     = 1'b0;
    winner_id = '0;
    idx       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_id) + k) % N_REQ);
      if (REQ[idx]) begin
        valid     = 1'b1;
        winner_id = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of one FIFO write port with bounded
// bursts, full stall and one-cycle clear sequencing. Optional: FIFO_ARB_WORD_COUNT_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int SIZE      = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     FLUSH,
  fifo_wr_arbiter_if.master        bus,
  output logic [$clog2(N_REQ)-1:0] GRANT_ID,
  output logic                     BUSY,
  output arb_state_t               STATE_DBG
`ifdef FIFO_ARB_WORD_COUNT_EN
  ,
  output logic [N_REQ*WORD_CNT_W-1:0] WR_COUNT
`endif
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  arb_state_t      state;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] last_id;
  logic [BC_W-1:0] burst_cnt;

  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic            req_sel;
  logic            wr_en;
  logic            burst_done;

  fifo_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .REQ       (bus.REQ),
    .last_id   (last_id),
    .valid     (pick_valid),
    .winner_id (pick_id)
  );

  assign req_sel    = bus.REQ[grant_id];
  // RESET and FLUSH both suppress the write in the cycle they are sampled.
  assign wr_en      = (state == GRANT) && !RESET && !FLUSH && req_sel && bus.F_FULL_N;
  assign burst_done = (burst_cnt == BC_W'(MAX_BURST - 1));

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      grant_id  <= '0;
      last_id   <= ID_W'(N_REQ - 1);
      burst_cnt <= '0;
    end else if (FLUSH) begin
      // A flushed burst counts as served so rotation moves past it.
      if (state == GRANT) last_id <= grant_id;
      state <= FLUSHING;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state     <= GRANT;
            grant_id  <= pick_id;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (wr_en) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_done) begin
              state   <= IDLE;
              last_id <= grant_id;
            end
          end else if (!req_sel) begin
            state   <= IDLE;
            last_id <= grant_id;
          end
        end
        FLUSHING: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ACK       = '0;
    bus.FIFO_DATA = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (wr_en && (grant_id == ID_W'(i))) begin
        bus.ACK[i]    = 1'b1;
        bus.FIFO_DATA = bus.DATA_REQ[i*SIZE +: SIZE];
      end
    end
  end

  assign bus.FIFO_WRITE   = wr_en;
  assign bus.FIFO_CLEAR_N = (state != FLUSHING);
  assign GRANT_ID         = grant_id;
  assign BUSY             = (state != IDLE);
  assign STATE_DBG        = state;

`ifdef FIFO_ARB_WORD_COUNT_EN
  logic [WORD_CNT_W-1:0] wr_cnt [N_REQ];

  always_ff @(posedge CLOCK) begin
    if (RESET || (state == FLUSHING)) begin
      for (int i = 0; i < N_REQ; i++) wr_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.ACK[i]) wr_cnt[i] <= wr_cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign WR_COUNT[g*WORD_CNT_W +: WORD_CNT_W] = wr_cnt[g];
  end
`endif

endmodule
